bus_responder_6502: RTL and testbench

- Memory-side responder for the 6502 core bus (AB/DI/DO/WE/RDY/IRQ). It is the target end of the CPU's initiator interface and replaces the ad-hoc memory model in simulation and FPGA builds.
- It provides a synchronous RAM across the whole address space, except one I/O page.
- The I/O page holds a programmable down-counter timer that drives the CPU's IRQ.
- I/O reads insert programmable wait states by deasserting RDY.

---
 rtl/bus_responder_6502.sv | 233 +++++++++++++++++++++++
 tb/tb_bus_responder_6502.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder_6502.sv
// -----------------------------------------------------------------------------
// bus_responder_6502
//
// Memory-side responder for the 6502 core bus. It is the target end of the
// CPU's initiator interface: a synchronous RAM covering the whole address
// space, except one 256-byte I/O page. That page holds a programmable 16-bit
// down-counter timer that drives the CPU's IRQ line. Reads of the I/O page are
// stretched with a programmable number of wait states by pulling RDY low.
//
// Parameters:
//   MEM_AW  - backing RAM address width; address bits above MEM_AW-1 are
//             ignored, so the RAM mirrors across the 64K space.
//   IO_PAGE - high address byte selecting the I/O page (RAM is never touched
//             for this page).
//   IO_WAIT - RDY-low cycles inserted per I/O read (0..7, 0 = no stall).
//
// Ports:
//   clk     in   1   system clock, all state on the rising edge
//   rst_n   in   1   asynchronous active-low reset
//   ab      in  16   CPU address bus
//   do_cpu  in   8   CPU write data
//   we      in   1   CPU write enable, active high
//   di_cpu  out  8   read data to CPU, registered (1-cycle latency)
//   rdy     out  1   CPU ready, combinational from ab/we/wait counter
//   irq     out  1   interrupt request to CPU, active high, registered
//
// I/O register map (offset = ab[7:0]):
//   0x00 RLD_LO  rw  reload value, low byte
//   0x01 RLD_HI  rw  reload value, high byte
//   0x02 CTRL    rw  bit0 EN, bit1 IE, bit2 AUTO
//   0x03 STAT    r   bit0 EXP; writing 1 to bit0 clears EXP
//   0x04 CNT_LO  r   live count, low byte
//   0x05 CNT_HI  r   live count, high byte
//   others           read 0, writes ignored
// -----------------------------------------------------------------------------
module bus_responder_6502 #(
  parameter int         MEM_AW  = 16,
  parameter logic [7:0] IO_PAGE = 8'hD0,
  parameter int         IO_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ab,
  input  logic [7:0]  do_cpu,
  input  logic        we,
  output logic [7:0]  di_cpu,
  output logic        rdy,
  output logic        irq
);

  // Wait-state target as a 3-bit value; the counter is only 3 bits wide, so
  // values above 7 would never be reached and are truncated here.
  localparam logic [2:0] IO_WAIT_C = 3'(IO_WAIT);

  localparam logic [7:0] OFF_RLD_LO = 8'h00;
  localparam logic [7:0] OFF_RLD_HI = 8'h01;
  localparam logic [7:0] OFF_CTRL   = 8'h02;
  localparam logic [7:0] OFF_STAT   = 8'h03;
  localparam logic [7:0] OFF_CNT_LO = 8'h04;
  localparam logic [7:0] OFF_CNT_HI = 8'h05;

  // Backing RAM. Deliberately not reset so it maps onto block RAM.
  logic [7:0] mem [0:(1<<MEM_AW)-1];

  // Registered state
  logic [7:0]  di_cpu_q,   di_cpu_d;
  logic        irq_q,      irq_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] rld_q,      rld_d;
  logic        en_q,       en_d;
  logic        ie_q,       ie_d;
  logic        auto_q,     auto_d;
  logic        exp_q,      exp_d;
  logic [15:0] cnt_q,      cnt_d;

  // Decode
  logic [MEM_AW-1:0] mem_idx;
  logic [7:0]        io_off;
  logic              io_hit;
  logic              io_rd;
  logic              io_wr;
  logic              rdy_int;
  logic [7:0]        io_rdata;
  logic              exp_set;

  // Upper address bits beyond MEM_AW are intentionally ignored (mirroring);
  // folding the whole bus here keeps them from showing up as dangling.
  logic unused_ab_bits;
  assign unused_ab_bits = ^ab;

  assign mem_idx = ab[MEM_AW-1:0];
  assign io_off  = ab[7:0];

  // Address decode and the ready handshake. An I/O read holds RDY low until
  // the wait counter has counted IO_WAIT stalled edges; the cycle after that
  // RDY is high and the read completes.
  always_comb begin
    io_hit  = (ab[15:8] == IO_PAGE);
    io_rd   = io_hit & ~we;
    io_wr   = io_hit & we;
    rdy_int = ~(io_rd & (wait_cnt_q != IO_WAIT_C));
  end

  assign rdy    = rdy_int;
  assign di_cpu = di_cpu_q;
  assign irq    = irq_q;

  // I/O read data mux over the register map.
  always_comb begin
    io_rdata = 8'h00;
    case (io_off)
      OFF_RLD_LO: io_rdata = rld_q[7:0];
      OFF_RLD_HI: io_rdata = rld_q[15:8];
      OFF_CTRL:   io_rdata = {5'b0, auto_q, ie_q, en_q};
      OFF_STAT:   io_rdata = {7'b0, exp_q};
      OFF_CNT_LO: io_rdata = cnt_q[7:0];
      OFF_CNT_HI: io_rdata = cnt_q[15:8];
      default:    io_rdata = 8'h00;
    endcase
  end

  // Wait counter and read data. The counter advances on stalled I/O read
  // edges and restarts on every completed cycle, so back-to-back I/O reads
  // each get their own full stall. Read data is only captured when RDY is
  // high; mem is sampled before this edge's write lands, giving
  // read-before-write behaviour on a same-address collision.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (rdy_int) begin
      wait_cnt_d = 3'd0;
    end else if (io_rd) begin
      wait_cnt_d = wait_cnt_q + 3'd1;
    end

    di_cpu_d = di_cpu_q;
    if (rdy_int) begin
      di_cpu_d = io_hit ? io_rdata : mem[mem_idx];
    end
  end

  // Timer next state. The hardware count step is computed first, then
  // software writes override it: a CTRL write wins for EN/IE/AUTO even on an
  // expiry edge. EXP is resolved last so a hardware expiry always beats a
  // software clear landing on the same edge.
  always_comb begin
    rld_d   = rld_q;
    en_d    = en_q;
    ie_d    = ie_q;
    auto_d  = auto_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    exp_set = 1'b0;

    if (en_q) begin
      if (cnt_q != 16'd0) begin
        cnt_d = cnt_q - 16'd1;
      end else begin
        exp_set = 1'b1;
        if (auto_q) begin
          cnt_d = rld_q;
        end else begin
          en_d = 1'b0;
        end
      end
    end

    if (io_wr) begin
      case (io_off)
        OFF_RLD_LO: rld_d[7:0]  = do_cpu;
        OFF_RLD_HI: rld_d[15:8] = do_cpu;
        OFF_CTRL: begin
          en_d   = do_cpu[0];
          ie_d   = do_cpu[1];
          auto_d = do_cpu[2];
          // Only a 0->1 transition of EN (re)loads the counter; rewriting
          // EN=1 while already running leaves the count alone.
          if (!en_q && do_cpu[0]) begin
            cnt_d = rld_q;
          end
        end
        OFF_STAT: begin
          if (do_cpu[0]) begin
            exp_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (exp_set) begin
      exp_d = 1'b1;
    end

    // IRQ is a registered copy of the masked flag, one cycle behind EXP.
    irq_d = exp_q & ie_q;
  end

  // RAM write port. I/O page writes go to the timer registers instead and
  // never disturb the RAM underneath.
  always_ff @(posedge clk) begin
    if (we && !io_hit) begin
      mem[mem_idx] <= do_cpu;
    end
  end

  // All resettable state. An asynchronous reset in the middle of a stall
  // clears the wait counter, so the first edge after release starts the
  // stall over for whatever request is then on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      di_cpu_q   <= 8'h00;
      irq_q      <= 1'b0;
      wait_cnt_q <= 3'd0;
      rld_q      <= 16'h0000;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      auto_q     <= 1'b0;
      exp_q      <= 1'b0;
      cnt_q      <= 16'h0000;
    end else begin
      di_cpu_q   <= di_cpu_d;
      irq_q      <= irq_d;
      wait_cnt_q <= wait_cnt_d;
      rld_q      <= rld_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      auto_q     <= auto_d;
      exp_q      <= exp_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_responder_6502.sv
// -----------------------------------------------------------------------------
// tb_bus_responder_6502
//
// Directed testbench for bus_responder_6502, built with MEM_AW=12 so the RAM
// mirror is visible and IO_WAIT=2. Each scenario task drives the bus and
// compares outputs against hand-computed values. Inputs change 2 time units
// after a rising edge; outputs are sampled at that same point or later.
// -----------------------------------------------------------------------------
module tb_bus_responder_6502;

  logic        clk;
  logic        rst_n;
  logic [15:0] ab;
  logic [7:0]  do_cpu;
  logic        we;
  logic [7:0]  di_cpu;
  logic        rdy;
  logic        irq;

  int total;
  int passed;

  bus_responder_6502 #(
    .MEM_AW (12),
    .IO_PAGE(8'hD0),
    .IO_WAIT(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ab    (ab),
    .do_cpu(do_cpu),
    .we    (we),
    .di_cpu(di_cpu),
    .rdy   (rdy),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance exactly one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Single-edge write, then park the bus on a RAM read of 0x0000.
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    ab = a;
    do_cpu = d;
    we = 1'b1;
    step();
    we = 1'b0;
    ab = 16'h0000;
    do_cpu = 8'h00;
  endtask

  // I/O read: holds the address through the stall, returns the captured data
  // and the number of RDY-low edges seen. Bounded against a stuck RDY.
  task automatic io_read(input logic [15:0] a, output logic [7:0] d, output int stalls);
    ab = a;
    we = 1'b0;
    stalls = 0;
    #1;
    while (rdy !== 1'b1 && stalls < 16) begin
      step();
      stalls++;
    end
    if (stalls >= 16) begin
      total++;
      $display("[TB] FAIL io_read_timeout addr %h: rdy stayed %b, required 1", a, rdy);
    end
    step();
    d = di_cpu;
    ab = 16'h0000;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    int st;
    rst_n = 1'b0;
    ab = 16'h0000;
    we = 1'b0;
    do_cpu = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    total++; if (di_cpu !== 8'h00) $display("[TB] FAIL reset_di got %h want 00", di_cpu); else passed++;
    total++; if (irq !== 1'b0) $display("[TB] FAIL reset_irq got %b want 0", irq); else passed++;
    total++; if (rdy !== 1'b1) $display("[TB] FAIL reset_rdy_ram got %b want 1", rdy); else passed++;
    ab = 16'hD002;
    #1;
    total++; if (rdy !== 1'b0) $display("[TB] FAIL reset_rdy_io got %b want 0", rdy); else passed++;
    ab = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    io_read(16'hD002, d, st);
    total++; if (d !== 8'h00) $display("[TB] FAIL reset_ctrl got %h want 00", d); else passed++;
    io_read(16'hD000, d, st);
    total++; if (d !== 8'h00) $display("[TB] FAIL reset_rld_lo got %h want 00", d); else passed++;
    io_read(16'hD004, d, st);
    total++; if (d !== 8'h00) $display("[TB] FAIL reset_cnt_lo got %h want 00", d); else passed++;
  endtask

  task automatic test_ram();
    ab = 16'h0200;
    do_cpu = 8'hA5;
    we = 1'b1;
    #1;
    total++; if (rdy !== 1'b1) $display("[TB] FAIL ram_wr_rdy got %b want 1", rdy); else passed++;
    step();
    we = 1'b0;
    #1;
    total++; if (rdy !== 1'b1) $display("[TB] FAIL ram_rd_rdy got %b want 1", rdy); else passed++;
    step();
    total++; if (di_cpu !== 8'hA5) $display("[TB] FAIL ram_roundtrip got %h want a5", di_cpu); else passed++;
    // Read-before-write on a same-address collision
    wr(16'h0300, 8'h11);
    ab = 16'h0300;
    do_cpu = 8'h22;
    we = 1'b1;
    step();
    total++; if (di_cpu !== 8'h11) $display("[TB] FAIL ram_rbw_old got %h want 11", di_cpu); else passed++;
    we = 1'b0;
    step();
    total++; if (di_cpu !== 8'h22) $display("[TB] FAIL ram_rbw_new got %h want 22", di_cpu); else passed++;
  endtask

  task automatic test_mirror_isolation();
    logic [7:0] d;
    int st;
    wr(16'h0010, 8'h77);
    wr(16'hD010, 8'h55);
    io_read(16'hD010, d, st);
    total++; if (d !== 8'h00) $display("[TB] FAIL io_unmapped got %h want 00", d); else passed++;
    total++; if (st != 2) $display("[TB] FAIL io_unmapped_stalls got %0d want 2", st); else passed++;
    ab = 16'h0010;
    step();
    total++; if (di_cpu !== 8'h77) $display("[TB] FAIL io_isolation_ram got %h want 77", di_cpu); else passed++;
    wr(16'h1123, 8'h3C);
    ab = 16'h0123;
    step();
    total++; if (di_cpu !== 8'h3C) $display("[TB] FAIL ram_mirror got %h want 3c", di_cpu); else passed++;
  endtask

  task automatic test_io_stall();
    // di_cpu holds 8'h3C from the mirror read; CTRL currently reads 00.
    ab = 16'hD002;
    we = 1'b0;
    #1;
    total++; if (rdy !== 1'b0) $display("[TB] FAIL stall_c0_rdy got %b want 0", rdy); else passed++;
    step();
    total++; if (rdy !== 1'b0) $display("[TB] FAIL stall_c1_rdy got %b want 0", rdy); else passed++;
    total++; if (di_cpu !== 8'h3C) $display("[TB] FAIL stall_c1_hold got %h want 3c", di_cpu); else passed++;
    step();
    total++; if (rdy !== 1'b1) $display("[TB] FAIL stall_c2_rdy got %b want 1", rdy); else passed++;
    total++; if (di_cpu !== 8'h3C) $display("[TB] FAIL stall_c2_hold got %h want 3c", di_cpu); else passed++;
    step();
    total++; if (di_cpu !== 8'h00) $display("[TB] FAIL stall_data got %h want 00", di_cpu); else passed++;
    total++; if (rdy !== 1'b0) $display("[TB] FAIL stall_b2b_rdy got %b want 0", rdy); else passed++;
    ab = 16'h0000;
    step();
  endtask

  task automatic test_oneshot();
    logic [7:0] d;
    int st;
    wr(16'hD000, 8'h08);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h03);
    // Count is 8 after the CTRL edge; each read spans 3 edges.
    io_read(16'hD004, d, st);
    total++; if (d !== 8'h06) $display("[TB] FAIL oneshot_cnt1 got %h want 06", d); else passed++;
    io_read(16'hD004, d, st);
    total++; if (d !== 8'h03) $display("[TB] FAIL oneshot_cnt2 got %h want 03", d); else passed++;
    io_read(16'hD004, d, st);
    total++; if (d !== 8'h00) $display("[TB] FAIL oneshot_cnt3 got %h want 00", d); else passed++;
    total++; if (irq !== 1'b0) $display("[TB] FAIL oneshot_irq_lag got %b want 0", irq); else passed++;
    io_read(16'hD003, d, st);
    total++; if (d !== 8'h01) $display("[TB] FAIL oneshot_exp got %h want 01", d); else passed++;
    total++; if (irq !== 1'b1) $display("[TB] FAIL oneshot_irq got %b want 1", irq); else passed++;
    io_read(16'hD002, d, st);
    total++; if (d !== 8'h02) $display("[TB] FAIL oneshot_ctrl got %h want 02", d); else passed++;
    io_read(16'hD004, d, st);
    total++; if (d !== 8'h00) $display("[TB] FAIL oneshot_cnt_stop got %h want 00", d); else passed++;
  endtask

  task automatic test_autoreload();
    logic [7:0] d;
    int st;
    wr(16'hD000, 8'h01);
    wr(16'hD001, 8'h00);
    wr(16'hD003, 8'h01);
    total++; if (irq !== 1'b1) $display("[TB] FAIL clr_irq_hold got %b want 1", irq); else passed++;
    step();
    total++; if (irq !== 1'b0) $display("[TB] FAIL clr_irq_drop got %b want 0", irq); else passed++;
    wr(16'hD002, 8'h07);
    step();
    step();
    // Expiry on the 2nd, 4th, 6th, 8th edges after the CTRL write.
    wr(16'hD003, 8'h01);
    total++; if (irq !== 1'b1) $display("[TB] FAIL auto_irq_first got %b want 1", irq); else passed++;
    step();
    total++; if (irq !== 1'b0) $display("[TB] FAIL auto_clr_drop got %b want 0", irq); else passed++;
    step();
    total++; if (irq !== 1'b1) $display("[TB] FAIL auto_reexp got %b want 1", irq); else passed++;
    wr(16'hD003, 8'h01);
    wr(16'hD003, 8'h01);
    total++; if (irq !== 1'b1) $display("[TB] FAIL auto_set_wins got %b want 1", irq); else passed++;
    wr(16'hD002, 8'h02);
    total++; if (irq !== 1'b0) $display("[TB] FAIL ctrl_exp_irq_lo got %b want 0", irq); else passed++;
    step();
    total++; if (irq !== 1'b1) $display("[TB] FAIL ctrl_exp_irq_hi got %b want 1", irq); else passed++;
    io_read(16'hD002, d, st);
    total++; if (d !== 8'h02) $display("[TB] FAIL ctrl_exp_ctrl got %h want 02", d); else passed++;
    io_read(16'hD003, d, st);
    total++; if (d !== 8'h01) $display("[TB] FAIL ctrl_exp_stat got %h want 01", d); else passed++;
    io_read(16'hD004, d, st);
    total++; if (d !== 8'h01) $display("[TB] FAIL ctrl_exp_cnt got %h want 01", d); else passed++;
  endtask

  task automatic test_reset_mid_stall();
    logic [7:0] d;
    int st;
    ab = 16'hD003;
    we = 1'b0;
    step();
    #1;
    total++; if (rdy !== 1'b0) $display("[TB] FAIL mid_pre_rdy got %b want 0", rdy); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (di_cpu !== 8'h00) $display("[TB] FAIL mid_di got %h want 00", di_cpu); else passed++;
    total++; if (irq !== 1'b0) $display("[TB] FAIL mid_irq got %b want 0", irq); else passed++;
    total++; if (rdy !== 1'b0) $display("[TB] FAIL mid_rdy got %b want 0", rdy); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    io_read(16'hD003, d, st);
    total++; if (st != 2) $display("[TB] FAIL mid_fresh_stalls got %0d want 2", st); else passed++;
    total++; if (d !== 8'h00) $display("[TB] FAIL mid_stat got %h want 00", d); else passed++;
    io_read(16'hD002, d, st);
    total++; if (d !== 8'h00) $display("[TB] FAIL mid_ctrl got %h want 00", d); else passed++;
    io_read(16'hD000, d, st);
    total++; if (d !== 8'h00) $display("[TB] FAIL mid_rld got %h want 00", d); else passed++;
    io_read(16'hD004, d, st);
    total++; if (d !== 8'h00) $display("[TB] FAIL mid_cnt got %h want 00", d); else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_ram();
    test_mirror_isolation();
    test_io_stall();
    test_oneshot();
    test_autoreload();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
